sipo: RTL and testbench

//   Serial-in, parallel-out shift register. Captures one serial bit per rising clk

---
 rtl/sipo.sv | 37 +++
 tb/tb_sipo.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sipo.sv
// Serial-in, parallel-out shift register; parallel_out driven straight from flops.
// Latency: a bit sampled on edge N is visible in the entry bit after edge N.
// Backpressure: none; every edge without rst shifts.
module sipo #(
    parameter int              WIDTH     = 4,
    parameter bit              MSB_FIRST = 1'b1,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    output logic [WIDTH-1:0] parallel_out
);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_nxt;

    // Entry end is bit 0 when MSB_FIRST, bit WIDTH-1 otherwise.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign sr_nxt = {sr[WIDTH-2:0], serial_in};
        end else begin : g_lsb_first
            assign sr_nxt = {serial_in, sr[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= RST_VAL;
        end else begin
            sr <= sr_nxt;
        end
    end

    assign parallel_out = sr;

endmodule

// File: tb/tb_sipo.sv
// Bench for sipo: default 4-bit MSB-first instance and an 8-bit LSB-first instance
// sharing clk/rst/serial_in; expected words are queued as stimulus is driven.
module tb_sipo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       serial_in = 1'b0;
    logic [3:0] dout4;
    logic [7:0] dout8;

    int errors = 0;
    int checks = 0;

    logic [3:0] q4[$];
    logic [7:0] q8[$];

    always #5 clk = ~clk;

    sipo u_dut4 (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .parallel_out (dout4)
    );

    sipo #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut8 (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .parallel_out (dout8)
    );

    // Change inputs midway between edges, then sample 1 time unit after the edge.
    task automatic apply(input logic r, input logic s);
        @(negedge clk);
        rst       = r;
        serial_in = s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [3:0] e4;
        logic [7:0] e8;
        q4.push_back(4'h0);
        q8.push_back(8'h00);
        apply(1'b1, 1'b0);
        e4 = q4.pop_front();
        e8 = q8.pop_front();
        checks++;
        if (dout4 !== e4) begin
            errors++;
            $display("FAIL reset4 got=%b exp=%b", dout4, e4);
        end
        checks++;
        if (dout8 !== e8) begin
            errors++;
            $display("FAIL reset8 got=%h exp=%h", dout8, e8);
        end
    endtask

    task automatic test_shift;
        logic       bits[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [3:0] exp[4]  = '{4'b0000, 4'b0001, 4'b0010, 4'b0101};
        logic [3:0] e4;
        for (int i = 0; i < 4; i++) begin
            q4.push_back(exp[i]);
            apply(1'b0, bits[i]);
            e4 = q4.pop_front();
            checks++;
            if (dout4 !== e4) begin
                errors++;
                $display("FAIL shift[%0d] got=%b exp=%b", i, dout4, e4);
            end
        end
    endtask

    task automatic test_mid_reset;
        logic [3:0] e4;
        q4.push_back(4'b0000);
        apply(1'b1, 1'b0);
        e4 = q4.pop_front();
        checks++;
        if (dout4 !== e4) begin
            errors++;
            $display("FAIL mid_reset got=%b exp=%b", dout4, e4);
        end
    endtask

    task automatic test_fill_overflow;
        logic [3:0] exp[10] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111,
                                4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        logic [3:0] e4;
        apply(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            q4.push_back(exp[i]);
            apply(1'b0, (i < 6) ? 1'b1 : 1'b0);
            e4 = q4.pop_front();
            checks++;
            if (dout4 !== e4) begin
                errors++;
                $display("FAIL fill[%0d] got=%b exp=%b", i, dout4, e4);
            end
        end
    endtask

    task automatic test_reset_priority;
        logic [3:0] e4;
        q4.push_back(4'b0000);
        apply(1'b1, 1'b1);
        e4 = q4.pop_front();
        checks++;
        if (dout4 !== e4) begin
            errors++;
            $display("FAIL rst_prio got=%b exp=%b", dout4, e4);
        end
        q4.push_back(4'b0001);
        apply(1'b0, 1'b1);
        e4 = q4.pop_front();
        checks++;
        if (dout4 !== e4) begin
            errors++;
            $display("FAIL rst_release got=%b exp=%b", dout4, e4);
        end
    endtask

    task automatic test_lsb_first;
        logic       bits[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [7:0] exp8[4] = '{8'h80, 8'h40, 8'hA0, 8'hD0};
        logic [3:0] exp4[4] = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
        logic [3:0] e4;
        logic [7:0] e8;
        apply(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            q4.push_back(exp4[i]);
            q8.push_back(exp8[i]);
            apply(1'b0, bits[i]);
            e4 = q4.pop_front();
            e8 = q8.pop_front();
            checks++;
            if (dout8 !== e8) begin
                errors++;
                $display("FAIL lsb8[%0d] got=%h exp=%h", i, dout8, e8);
            end
            checks++;
            if (dout4 !== e4) begin
                errors++;
                $display("FAIL msb4[%0d] got=%b exp=%b", i, dout4, e4);
            end
        end
    endtask

    task automatic test_x_passthrough;
        logic [3:0] e4;
        apply(1'b1, 1'b0);
        q4.push_back(4'b000x);
        apply(1'b0, 1'bx);
        e4 = q4.pop_front();
        checks++;
        if (dout4 !== e4) begin
            errors++;
            $display("FAIL x_in got=%b exp=%b", dout4, e4);
        end
        for (int i = 0; i < 4; i++) apply(1'b0, 1'b0);
        q4.push_back(4'b0000);
        e4 = q4.pop_front();
        checks++;
        if (dout4 !== e4) begin
            errors++;
            $display("FAIL x_flush got=%b exp=%b", dout4, e4);
        end
    endtask

    // Random stream against a bit-history model: index k of hist is the bit k edges ago.
    task automatic test_back_to_back;
        logic [31:0] hist = '0;
        logic [3:0]  m4;
        logic [7:0]  m8;
        logic [3:0]  e4;
        logic [7:0]  e8;
        logic        b;
        apply(1'b1, 1'b0);
        for (int n = 0; n < 40; n++) begin
            b    = 1'($urandom_range(0, 1));
            hist = {hist[30:0], b};
            for (int k = 0; k < 4; k++) m4[k] = hist[k];
            for (int k = 0; k < 8; k++) m8[7-k] = hist[k];
            q4.push_back(m4);
            q8.push_back(m8);
            apply(1'b0, b);
            e4 = q4.pop_front();
            e8 = q8.pop_front();
            checks++;
            if (dout4 !== e4) begin
                errors++;
                $display("FAIL rand4[%0d] got=%b exp=%b", n, dout4, e4);
            end
            checks++;
            if (dout8 !== e8) begin
                errors++;
                $display("FAIL rand8[%0d] got=%h exp=%h", n, dout8, e8);
            end
        end
    endtask

    initial begin
        test_reset();
        test_shift();
        test_mid_reset();
        test_fill_overflow();
        test_reset_priority();
        test_lsb_first();
        test_x_passthrough();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
